branch_pc_unit: RTL and testbench

Parametrised program-counter and control-transfer unit for the rv32i core. It owns the PC register and resolves every RV32I control transfer: all six B-type conditions, JAL and JALR. It also applies a configurable post-redirect flush window and a sticky misaligned-target fault. It replaces the single BEQ/enable path in the data path, feeds `pc` to instruction memory and `link` to the register-file write-back mux.

---
 rtl/rv_pkg.sv | 11 +
 rtl/branch_cmp.sv | 24 ++
 rtl/branch_pc_unit.sv | 98 +++++++++
 tb/tb_branch_pc_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I control-transfer encodings, unit states and alignment constant
package rv_pkg;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;
   localparam int IALIGN = 32;
   typedef enum logic [1:0] {RUN, FLUSH, FAULT} state_e;
endpackage

// File: rtl/branch_cmp.sv
// branch_cmp: B-type condition evaluation and illegal funct3 detection
module branch_cmp
   import rv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic [2:0]      f3,
   output logic            cond,
   output logic            illegal
);
   logic eq, lt, ltu;
   assign eq      = rs1_val == rs2_val;
   assign lt      = $signed(rs1_val) < $signed(rs2_val);
   assign ltu     = rs1_val < rs2_val;
   assign illegal = f3 == 3'b010 || f3 == 3'b011;
   assign cond    = f3 == F3_BEQ  ? eq   :
                    f3 == F3_BNE  ? !eq  :
                    f3 == F3_BLT  ? lt   :
                    f3 == F3_BGE  ? !lt  :
                    f3 == F3_BLTU ? ltu  :
                    f3 == F3_BGEU ? !ltu : 1'b0;
endmodule

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: PC register and RV32I branch/JAL/JALR resolution with flush window and sticky fault
module branch_pc_unit
   import rv_pkg::*;
#(
   parameter int             XLEN        = 32,
   parameter int             PC_W        = 16,
   parameter logic [PC_W-1:0] RESET_PC   = '0,
   parameter int             FLUSH_DEPTH = 2,
   parameter int             CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid,
   input  logic             branch,
   input  logic             jal,
   input  logic             jalr,
   input  logic [2:0]       f3,
   input  logic [XLEN-1:0]  rs1_val,
   input  logic [XLEN-1:0]  rs2_val,
   input  logic [XLEN-1:0]  imm,
   output logic [PC_W-1:0]  pc,
   output logic [PC_W-1:0]  link,
   output logic             taken,
   output logic             flush,
   output logic             fault,
   output logic [PC_W-1:0]  fault_pc,
   output logic [CNT_W-1:0] taken_cnt
);
   localparam int FW = FLUSH_DEPTH > 1 ? $clog2(FLUSH_DEPTH + 1) : 1;
   localparam int AB = $clog2(IALIGN / 8);
   state_e           state_q;
   logic [FW-1:0]    fcnt_q;
   logic [PC_W-1:0]  pc_q, fault_pc_q, jalr_sum, target;
   logic [CNT_W-1:0] tcnt_q;
   logic             flush_q, fault_q, cond, illegal, run, xfer, mis, fault_ev;
   branch_cmp #(.XLEN(XLEN)) u_cmp (
      .rs1_val (rs1_val),
      .rs2_val (rs2_val),
      .f3      (f3),
      .cond    (cond),
      .illegal (illegal)
   );
   // jalr > jal > branch; an illegal funct3 only matters when the branch is the selected transfer
   assign jalr_sum = rs1_val[PC_W-1:0] + imm[PC_W-1:0];
   assign target   = jalr ? {jalr_sum[PC_W-1:1], 1'b0} : pc_q + imm[PC_W-1:0];
   assign run      = state_q == RUN && valid;
   assign xfer     = jalr | jal | (branch & cond);
   assign mis      = |target[AB-1:1];
   assign fault_ev = run & ((branch & ~jal & ~jalr & illegal) | (xfer & mis));
   assign taken    = run & xfer & ~mis;
   assign link     = pc_q + PC_W'(4);
   assign pc        = pc_q;
   assign flush     = flush_q;
   assign fault     = fault_q;
   assign fault_pc  = fault_pc_q;
   assign taken_cnt = tcnt_q;
   // control FSM: RUN resolves transfers, FLUSH streams sequential PCs, FAULT freezes until reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         fcnt_q     <= '0;
         pc_q       <= RESET_PC;
         flush_q    <= 1'b0;
         fault_q    <= 1'b0;
         fault_pc_q <= '0;
         tcnt_q     <= '0;
      end else begin
         case (state_q)
            RUN: begin
               if (fault_ev) begin
                  state_q    <= FAULT;
                  fault_q    <= 1'b1;
                  fault_pc_q <= pc_q;
               end else if (taken) begin
                  pc_q <= target;
                  if (~&tcnt_q) tcnt_q <= tcnt_q + 1'b1;
                  if (FLUSH_DEPTH > 0) begin
                     state_q <= FLUSH;
                     flush_q <= 1'b1;
                     fcnt_q  <= FW'(FLUSH_DEPTH);
                  end
               end else if (valid) begin
                  pc_q <= link;
               end
            end
            FLUSH: begin
               pc_q   <= link;
               fcnt_q <= fcnt_q - 1'b1;
               if (fcnt_q == FW'(1)) begin
                  state_q <= RUN;
                  flush_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: directed vectors against a behavioural PC/transfer model plus literal pins
module tb_branch_pc_unit;
   localparam int PC_W = 16;
   localparam int FD   = 2;
   localparam int CW   = 2;
   localparam logic [31:0] MASK = 32'h0000_FFFF;
   localparam logic [31:0] CMAX = 32'd3;

   logic clk = 0, rst_n = 0, valid = 0, branch = 0, jal = 0, jalr = 0;
   logic [2:0]  f3 = 0;
   logic [31:0] rs1_val = 0, rs2_val = 0, imm = 0;
   logic [PC_W-1:0] pc, link, fault_pc;
   logic taken, flush, fault;
   logic [CW-1:0] taken_cnt;

   branch_pc_unit #(.XLEN(32), .PC_W(PC_W), .RESET_PC('0), .FLUSH_DEPTH(FD), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .valid(valid), .branch(branch), .jal(jal), .jalr(jalr),
      .f3(f3), .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
      .pc(pc), .link(link), .taken(taken), .flush(flush), .fault(fault),
      .fault_pc(fault_pc), .taken_cnt(taken_cnt)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // model state: architectural PC, remaining flush cycles, sticky fault, counter
   logic [31:0] m_pc = 0, m_fpc = 0, m_fl = 0, m_cnt = 0;
   logic m_fault = 0;
   logic [31:0] e_tgt;
   logic e_c, e_run, e_x, e_fev, e_taken;

   always_comb begin
      e_tgt = jalr ? ((rs1_val + imm) & MASK & ~32'h1) : ((m_pc + imm) & MASK);
      e_c = f3 == 3'd0 ? rs1_val == rs2_val :
            f3 == 3'd1 ? rs1_val != rs2_val :
            f3 == 3'd4 ? $signed(rs1_val) <  $signed(rs2_val) :
            f3 == 3'd5 ? $signed(rs1_val) >= $signed(rs2_val) :
            f3 == 3'd6 ? rs1_val <  rs2_val :
            f3 == 3'd7 ? rs1_val >= rs2_val : 1'b0;
      e_run   = rst_n && m_fl == 0 && !m_fault && valid;
      e_x     = jalr || jal || (branch && e_c);
      e_fev   = e_run && ((branch && !jal && !jalr && (f3 == 3'd2 || f3 == 3'd3)) || (e_x && e_tgt[1]));
      e_taken = e_run && e_x && !e_tgt[1];
   end

   always @(posedge clk) begin
      if (rst_n) begin
         if (m_fault) begin
         end else if (m_fl > 0) begin
            m_pc = (m_pc + 4) & MASK;
            m_fl = m_fl - 1;
         end else if (e_fev) begin
            m_fault = 1;
            m_fpc   = m_pc;
         end else if (e_taken) begin
            m_pc = e_tgt;
            if (m_cnt < CMAX) m_cnt = m_cnt + 1;
            m_fl = FD;
         end else if (valid) begin
            m_pc = (m_pc + 4) & MASK;
         end
      end
   end

   always @(negedge rst_n) begin
      m_pc = 0; m_fpc = 0; m_fl = 0; m_cnt = 0; m_fault = 0;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("pc", 32'(pc), m_pc);
         chk("link", 32'(link), (m_pc + 4) & MASK);
         chk("taken", 32'(taken), 32'(e_taken));
         chk("flush", 32'(flush), 32'(m_fl > 0));
         chk("fault", 32'(fault), 32'(m_fault));
         chk("fault_pc", 32'(fault_pc), m_fpc);
         chk("taken_cnt", 32'(taken_cnt), m_cnt);
      end
   end

   task automatic drv(input logic v, input logic br, input logic jl, input logic jr,
                      input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
      valid = v; branch = br; jal = jl; jalr = jr; f3 = f; rs1_val = a; rs2_val = b; imm = im;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      drv(0, 0, 0, 0, 3'd0, 0, 0, 0);
   endtask

   task automatic pulse_reset(input string nm);
      #2 rst_n = 0;
      #1;
      chk({nm, "_pc"}, 32'(pc), 32'h0);
      chk({nm, "_flush"}, 32'(flush), 32'h0);
      chk({nm, "_fault"}, 32'(fault), 32'h0);
      chk({nm, "_cnt"}, 32'(taken_cnt), 32'h0);
      #3 rst_n = 1;
   endtask

   initial begin
      idle();
      #12;
      chk("rst_pc", 32'(pc), 32'h0);
      chk("rst_flush", 32'(flush), 32'h0);
      chk("rst_fault", 32'(fault), 32'h0);
      chk("rst_fault_pc", 32'(fault_pc), 32'h0);
      chk("rst_cnt", 32'(taken_cnt), 32'h0);
      rst_n = 1;
      // BEQ 5==5, +36 from pc 0
      drv(1, 1, 0, 0, 3'd0, 5, 5, 36);
      #1 chk("beq_taken", 32'(taken), 32'h1);
      chk("beq_link", 32'(link), 32'h4);
      tick();
      chk("beq_pc", 32'(pc), 32'd36);
      chk("beq_flush", 32'(flush), 32'h1);
      chk("beq_cnt", 32'(taken_cnt), 32'h1);
      drv(1, 1, 1, 1, 3'd0, 0, 0, 100);
      tick();
      chk("fl1_pc", 32'(pc), 32'd40);
      chk("fl1_flush", 32'(flush), 32'h1);
      tick();
      chk("fl2_pc", 32'(pc), 32'd44);
      chk("fl2_flush", 32'(flush), 32'h0);
      // BEQ 0 vs 21 not taken
      drv(1, 1, 0, 0, 3'd0, 0, 21, 32'hFFFF_FFDC);
      #1 chk("beqn_taken", 32'(taken), 32'h0);
      tick();
      chk("beqn_pc", 32'(pc), 32'd48);
      chk("beqn_flush", 32'(flush), 32'h0);
      // signed vs unsigned with rs1=-1, rs2=1
      drv(1, 1, 0, 0, 3'd4, 32'hFFFF_FFFF, 1, 8);
      #1 chk("blt", 32'(taken), 32'h1);
      f3 = 3'd6;
      #1 chk("bltu", 32'(taken), 32'h0);
      f3 = 3'd5;
      #1 chk("bge", 32'(taken), 32'h0);
      f3 = 3'd7;
      #1 chk("bgeu", 32'(taken), 32'h1);
      tick();
      chk("bgeu_pc", 32'(pc), 32'd56);
      chk("bgeu_cnt", 32'(taken_cnt), 32'h2);
      idle();
      tick();
      tick();
      chk("fl_stall_pc", 32'(pc), 32'd64);
      // RUN stall holds pc even with jal asserted
      drv(0, 0, 1, 0, 3'd0, 0, 0, 100);
      #1 chk("stall_taken", 32'(taken), 32'h0);
      tick();
      chk("stall_pc", 32'(pc), 32'd64);
      // JALR misaligned target 0x102
      drv(1, 0, 0, 1, 3'd0, 32'h101, 0, 2);
      #1 chk("jalr_mis_taken", 32'(taken), 32'h0);
      tick();
      chk("jalr_fault", 32'(fault), 32'h1);
      chk("jalr_fault_pc", 32'(fault_pc), 32'd64);
      chk("jalr_pc", 32'(pc), 32'd64);
      for (int i = 0; i < 10; i++) begin
         drv(1, i[0], 1, i[1], 3'(i), 32'(i), 0, 32'(4 * i));
         tick();
      end
      chk("frozen_pc", 32'(pc), 32'd64);
      chk("frozen_fault", 32'(fault), 32'h1);
      chk("frozen_cnt", 32'(taken_cnt), 32'h2);
      pulse_reset("rst_fault");
      // JAL -8 from pc 4 wraps to 0xFFFC
      drv(1, 0, 0, 0, 3'd0, 0, 0, 0);
      tick();
      drv(1, 0, 1, 0, 3'd0, 0, 0, 32'hFFFF_FFF8);
      #1 chk("jal_link", 32'(link), 32'h8);
      chk("jal_taken", 32'(taken), 32'h1);
      tick();
      chk("jal_pc", 32'(pc), 32'hFFFC);
      chk("jal_cnt", 32'(taken_cnt), 32'h1);
      idle();
      tick();
      chk("wrap_pc", 32'(pc), 32'h0);
      tick();
      chk("wrap_pc2", 32'(pc), 32'h4);
      // illegal funct3 faults even though nothing is taken
      drv(1, 1, 0, 0, 3'd2, 7, 7, 16);
      #1 chk("ill_taken", 32'(taken), 32'h0);
      tick();
      chk("ill_fault", 32'(fault), 32'h1);
      chk("ill_fault_pc", 32'(fault_pc), 32'h4);
      pulse_reset("rst_ill");
      // stall, BNE taken, reset mid-flush
      idle();
      tick();
      chk("pre_stall_pc", 32'(pc), 32'h0);
      drv(1, 1, 0, 0, 3'd1, 1, 2, 32'h20);
      tick();
      chk("bne_pc", 32'(pc), 32'h20);
      idle();
      tick();
      chk("bne_fl_pc", 32'(pc), 32'h24);
      chk("bne_fl_flush", 32'(flush), 32'h1);
      pulse_reset("rst_flush");
      drv(1, 0, 0, 0, 3'd0, 0, 0, 0);
      tick();
      chk("post_rst_pc", 32'(pc), 32'h4);
      chk("post_rst_flush", 32'(flush), 32'h0);
      // counter saturates at 3 with CNT_W=2
      for (int i = 0; i < 4; i++) begin
         drv(1, 0, 1, 0, 3'd0, 0, 0, 8);
         tick();
         idle();
         tick();
         tick();
      end
      chk("sat_cnt", 32'(taken_cnt), 32'h3);
      chk("sat_pc", 32'(pc), 32'h44);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
